operand_b_fwd_stage: RTL and testbench

- Parametrised, registered operand-B select and forwarding stage at the ID/EX boundary of the pipelined datapath.
- Selects among the constant, register-file data, the EX-stage forward and the WB-stage BUS_D, with fixed priority.
- Detects load-use hazards and drives a multi-cycle stall through a small state machine.
- Registers the chosen operand into the EX stage with a valid bit; handles flush.

---
 rtl/operand_b_fwd_stage.sv | 153 +++++++++++++++
 tb/tb_operand_b_fwd_stage.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_b_fwd_stage.sv
// Operand-B select/forward stage at the ID/EX boundary with load-use stall control.
// Optional performance counters are built only when OPB_FWD_PERF_EN is defined.
module operand_b_fwd_stage #(
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CW       = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic          id_mb,
  input  logic [AW-1:0] id_rb_addr,
  input  logic [DW-1:0] id_b_data,
  input  logic [DW-1:0] id_const,
  input  logic          flush,
  input  logic          ex_wr_en,
  input  logic [AW-1:0] ex_wr_addr,
  input  logic          ex_is_load,
  input  logic [DW-1:0] ex_result,
  input  logic          wb_wr_en,
  input  logic [AW-1:0] wb_wr_addr,
  input  logic [DW-1:0] bus_d,
  output logic          stall,
  output logic [DW-1:0] bus_b_q,
  output logic          bus_b_valid_q,
  output logic [1:0]    src_q,
  output logic [CW-1:0] ex_fwd_cnt,
  output logic [CW-1:0] wb_fwd_cnt,
  output logic [CW-1:0] stall_cnt
);

  localparam int unsigned CNT_W = 3;
  localparam logic [1:0] SRC_RF    = 2'd0;
  localparam logic [1:0] SRC_CONST = 2'd1;
  localparam logic [1:0] SRC_EX    = 2'd2;
  localparam logic [1:0] SRC_WB    = 2'd3;

  typedef enum logic {RUN, STALL} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             mask, mask_nxt;
  logic             ex_hit, wb_hit, ex_hit_eff, load_use, bubble;
  logic [DW-1:0]    sel_data;
  logic [1:0]       sel_src;

  // EX is blind while stalling and for one cycle after: that slot is a bubble.
  assign ex_hit     = ex_wr_en && (ex_wr_addr == id_rb_addr) && (id_rb_addr != '0);
  assign wb_hit     = wb_wr_en && (wb_wr_addr == id_rb_addr) && (id_rb_addr != '0);
  assign ex_hit_eff = ex_hit && !mask && (state == RUN);
  assign load_use   = id_valid && !id_mb && ex_hit_eff && ex_is_load;
  assign bubble     = stall || flush || !id_valid;

  // Fixed-priority operand select: constant, EX, WB, register file.
  always_comb begin
    sel_data = id_b_data;
    sel_src  = SRC_RF;
    if (id_mb) begin
      sel_data = id_const;
      sel_src  = SRC_CONST;
    end else if (ex_hit_eff) begin
      sel_data = ex_result;
      sel_src  = SRC_EX;
    end else if (wb_hit) begin
      sel_data = bus_d;
      sel_src  = SRC_WB;
    end
  end

  // cnt holds the stall cycles still owed, including the current STALL cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mask_nxt  = 1'b0;
    stall     = 1'b0;
    if (flush) begin
      state_nxt = RUN;
      cnt_nxt   = '0;
    end else begin
      case (state)
        RUN: begin
          if (load_use) begin
            stall = 1'b1;
            if (LOAD_LAT == 1) begin
              mask_nxt = 1'b1;
            end else begin
              state_nxt = STALL;
              cnt_nxt   = CNT_W'(LOAD_LAT - 1);
            end
          end
        end
        STALL: begin
          stall = 1'b1;
          if (cnt <= CNT_W'(1)) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
            mask_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
      mask  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      mask  <= mask_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      bus_b_valid_q <= 1'b0;
      bus_b_q       <= '0;
      src_q         <= SRC_RF;
    end else begin
      bus_b_valid_q <= 1'b1;
      bus_b_q       <= sel_data;
      src_q         <= sel_src;
    end
  end

`ifdef OPB_FWD_PERF_EN
  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_fwd_cnt <= '0;
      wb_fwd_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (!bubble && (sel_src == SRC_EX) && (ex_fwd_cnt != '1))
        ex_fwd_cnt <= ex_fwd_cnt + CW'(1);
      if (!bubble && (sel_src == SRC_WB) && (wb_fwd_cnt != '1))
        wb_fwd_cnt <= wb_fwd_cnt + CW'(1);
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CW'(1);
    end
  end
`else
  assign ex_fwd_cnt = '0;
  assign wb_fwd_cnt = '0;
  assign stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_operand_b_fwd_stage.sv
// Bench for operand_b_fwd_stage: LOAD_LAT=1 and LOAD_LAT=3 instances share stimulus
// and are checked against a hazard-window reference model.
module tb_operand_b_fwd_stage;

  logic        clk = 1'b0;
  logic        reset, id_valid, id_mb, flush, ex_wr_en, ex_is_load, wb_wr_en;
  logic [4:0]  id_rb_addr, ex_wr_addr, wb_wr_addr;
  logic [31:0] id_b_data, id_const, ex_result, bus_d;

  wire [1:0]        st_w, bv_w;
  wire [1:0][1:0]   src_w;
  wire [1:0][31:0]  bb_w;
  wire [1:0][15:0]  cex_w, cwb_w, cst_w;

  always #5 clk = ~clk;

  operand_b_fwd_stage #(.LOAD_LAT(1)) u_lat1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_mb(id_mb), .id_rb_addr(id_rb_addr),
    .id_b_data(id_b_data), .id_const(id_const), .flush(flush), .ex_wr_en(ex_wr_en),
    .ex_wr_addr(ex_wr_addr), .ex_is_load(ex_is_load), .ex_result(ex_result),
    .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .bus_d(bus_d), .stall(st_w[0]),
    .bus_b_q(bb_w[0]), .bus_b_valid_q(bv_w[0]), .src_q(src_w[0]),
    .ex_fwd_cnt(cex_w[0]), .wb_fwd_cnt(cwb_w[0]), .stall_cnt(cst_w[0]));

  operand_b_fwd_stage #(.LOAD_LAT(3)) u_lat3 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_mb(id_mb), .id_rb_addr(id_rb_addr),
    .id_b_data(id_b_data), .id_const(id_const), .flush(flush), .ex_wr_en(ex_wr_en),
    .ex_wr_addr(ex_wr_addr), .ex_is_load(ex_is_load), .ex_result(ex_result),
    .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .bus_d(bus_d), .stall(st_w[1]),
    .bus_b_q(bb_w[1]), .bus_b_valid_q(bv_w[1]), .src_q(src_w[1]),
    .ex_fwd_cnt(cex_w[1]), .wb_fwd_cnt(cwb_w[1]), .stall_cnt(cst_w[1]));

  int errors = 0;
  int checks = 0;

  // Model: a hazard starting at cycle h stalls cycles h..h+L-1 and blinds EX for h+1..h+L.
  longint      cyc = 0;
  longint      hz[2];
  bit          hv[2];
  int          lat[2] = '{1, 3};
  int          m_ex[2], m_wb[2], m_st[2];
  bit          exp_st[2], act_st[2];
  logic [34:0] exp_out[2];

  function automatic int cnt_exp(input int v);
`ifdef OPB_FWD_PERF_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic model_reset();
    for (int ln = 0; ln < 2; ln++) begin
      hv[ln] = 1'b0; hz[ln] = 0;
      m_ex[ln] = 0; m_wb[ln] = 0; m_st[ln] = 0;
    end
  endtask

  task automatic model_step(input int ln);
    bit win, blind, exh, wbh, st;
    logic [31:0] d;
    logic [1:0]  s;
    win   = hv[ln] && (cyc > hz[ln]) && (cyc < hz[ln] + lat[ln]);
    blind = hv[ln] && (cyc > hz[ln]) && (cyc <= hz[ln] + lat[ln]);
    exh   = ex_wr_en && (ex_wr_addr == id_rb_addr) && (id_rb_addr != 5'd0) && !blind;
    wbh   = wb_wr_en && (wb_wr_addr == id_rb_addr) && (id_rb_addr != 5'd0);
    if (flush) begin
      st = 1'b0;
      hv[ln] = 1'b0;
    end else if (win) begin
      st = 1'b1;
    end else begin
      st = id_valid && !id_mb && exh && ex_is_load;
      if (st) begin hv[ln] = 1'b1; hz[ln] = cyc; end
    end
    if (id_mb)    begin s = 2'd1; d = id_const;  end
    else if (exh) begin s = 2'd2; d = ex_result; end
    else if (wbh) begin s = 2'd3; d = bus_d;     end
    else          begin s = 2'd0; d = id_b_data; end
    exp_st[ln] = st;
    if (st || flush || !id_valid) exp_out[ln] = '0;
    else begin
      exp_out[ln] = {1'b1, s, d};
      if (s == 2'd2) m_ex[ln]++;
      if (s == 2'd3) m_wb[ln]++;
    end
    if (st) m_st[ln]++;
  endtask

  // Inputs are set by the caller just after a rising edge.
  task automatic apply();
    #1;
    act_st[0] = st_w[0];
    act_st[1] = st_w[1];
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    id_valid = 0; id_mb = 0; flush = 0; ex_wr_en = 0; ex_is_load = 0; wb_wr_en = 0;
    id_rb_addr = '0; ex_wr_addr = '0; wb_wr_addr = '0;
    id_b_data = $urandom; id_const = $urandom; ex_result = $urandom; bus_d = $urandom;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    for (int ln = 0; ln < 2; ln++) begin
      checks++;
      if ({bv_w[ln], src_w[ln], bb_w[ln], st_w[ln]} !== 36'd0) begin
        errors++;
        $display("FAIL reset_outputs lane%0d got=%h expected=0", ln, {bv_w[ln], src_w[ln], bb_w[ln], st_w[ln]});
      end
      checks++;
      if ({cex_w[ln], cwb_w[ln], cst_w[ln]} !== 48'd0) begin
        errors++;
        $display("FAIL reset_counters lane%0d got=%h expected=0", ln, {cex_w[ln], cwb_w[ln], cst_w[ln]});
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_const();
    idle();
    id_valid = 1; id_mb = 1; id_const = 32'h0000_00FF; id_rb_addr = 5'd3;
    ex_wr_en = 1; ex_wr_addr = 5'd3; ex_is_load = 1;
    apply();
    for (int ln = 0; ln < 2; ln++) begin
      checks++;
      if (act_st[ln] !== exp_st[ln]) begin
        errors++; $display("FAIL const_stall lane%0d got=%0b expected=%0b", ln, act_st[ln], exp_st[ln]);
      end
      checks++;
      if ({bv_w[ln], src_w[ln], bb_w[ln]} !== exp_out[ln]) begin
        errors++; $display("FAIL const_out lane%0d got=%h expected=%h", ln, {bv_w[ln], src_w[ln], bb_w[ln]}, exp_out[ln]);
      end
    end
    checks++;
    if ({act_st[0], src_w[0], bb_w[0]} !== {1'b0, 2'd1, 32'h0000_00FF}) begin
      errors++; $display("FAIL const_literal got=%h expected=%h", {act_st[0], src_w[0], bb_w[0]}, {1'b0, 2'd1, 32'h0000_00FF});
    end
  endtask

  task automatic test_ex_priority();
    idle();
    id_valid = 1; id_rb_addr = 5'd3; ex_wr_en = 1; ex_wr_addr = 5'd3; ex_result = 32'h11;
    wb_wr_en = 1; wb_wr_addr = 5'd3; bus_d = 32'h22;
    apply();
    for (int ln = 0; ln < 2; ln++) begin
      checks++;
      if ({bv_w[ln], src_w[ln], bb_w[ln]} !== exp_out[ln]) begin
        errors++; $display("FAIL ex_prio_out lane%0d got=%h expected=%h", ln, {bv_w[ln], src_w[ln], bb_w[ln]}, exp_out[ln]);
      end
      checks++;
      if (cex_w[ln] !== 16'(cnt_exp(m_ex[ln]))) begin
        errors++; $display("FAIL ex_fwd_cnt lane%0d got=%0d expected=%0d", ln, cex_w[ln], cnt_exp(m_ex[ln]));
      end
    end
    checks++;
    if ({src_w[1], bb_w[1]} !== {2'd2, 32'h11}) begin
      errors++; $display("FAIL ex_prio_literal got=%h expected=%h", {src_w[1], bb_w[1]}, {2'd2, 32'h11});
    end
  endtask

  task automatic test_r0();
    idle();
    id_valid = 1; id_rb_addr = 5'd0; ex_wr_en = 1; ex_wr_addr = 5'd0; ex_is_load = 1;
    wb_wr_en = 1; wb_wr_addr = 5'd0; id_b_data = 32'd0;
    for (int k = 0; k < 2; k++) begin
      apply();
      for (int ln = 0; ln < 2; ln++) begin
        checks++;
        if (act_st[ln] !== exp_st[ln]) begin
          errors++; $display("FAIL r0_stall lane%0d got=%0b expected=%0b", ln, act_st[ln], exp_st[ln]);
        end
        checks++;
        if ({bv_w[ln], src_w[ln], bb_w[ln]} !== exp_out[ln]) begin
          errors++; $display("FAIL r0_out lane%0d got=%h expected=%h", ln, {bv_w[ln], src_w[ln], bb_w[ln]}, exp_out[ln]);
        end
      end
      id_b_data = $urandom;
    end
  endtask

  task automatic test_load_use_lat1();
    idle();
    id_valid = 1; id_rb_addr = 5'd5; ex_wr_en = 1; ex_wr_addr = 5'd5; ex_is_load = 1;
    apply();
    checks++;
    if ({act_st[0], bv_w[0]} !== 2'b10) begin
      errors++; $display("FAIL lat1_stall_bubble got=%b expected=10", {act_st[0], bv_w[0]});
    end
    ex_is_load = 0; ex_result = 32'hDEAD_0000; wb_wr_en = 1; wb_wr_addr = 5'd5; bus_d = 32'h0000_ABCD;
    for (int k = 0; k < 4; k++) begin
      apply();
      if (k == 0) begin
        checks++;
        if ({src_w[0], bb_w[0]} !== {2'd3, 32'h0000_ABCD}) begin
          errors++; $display("FAIL lat1_wb_pickup got=%h expected=%h", {src_w[0], bb_w[0]}, {2'd3, 32'h0000_ABCD});
        end
      end
      for (int ln = 0; ln < 2; ln++) begin
        checks++;
        if (act_st[ln] !== exp_st[ln]) begin
          errors++; $display("FAIL lat1_seq_stall lane%0d got=%0b expected=%0b", ln, act_st[ln], exp_st[ln]);
        end
        checks++;
        if ({bv_w[ln], src_w[ln], bb_w[ln]} !== exp_out[ln]) begin
          errors++; $display("FAIL lat1_seq_out lane%0d got=%h expected=%h", ln, {bv_w[ln], src_w[ln], bb_w[ln]}, exp_out[ln]);
        end
      end
    end
  endtask

  task automatic test_load_use_lat3();
    int n_stall, n_bub;
    idle();
    n_stall = 0; n_bub = 0;
    id_valid = 1; id_rb_addr = 5'd6; ex_wr_en = 1; ex_wr_addr = 5'd6; ex_is_load = 1;
    for (int k = 0; k < 5; k++) begin
      apply();
      n_stall += int'(act_st[1]);
      n_bub   += int'(!bv_w[1]);
      checks++;
      if ({bv_w[1], src_w[1], bb_w[1]} !== exp_out[1]) begin
        errors++; $display("FAIL lat3_out cycle%0d got=%h expected=%h", k, {bv_w[1], src_w[1], bb_w[1]}, exp_out[1]);
      end
      ex_wr_en = 0; ex_is_load = 0; wb_wr_en = 1; wb_wr_addr = 5'd6;
    end
    checks++;
    if (n_stall != 3) begin
      errors++; $display("FAIL lat3_stall_cycles got=%0d expected=3", n_stall);
    end
    checks++;
    if (n_bub != 3) begin
      errors++; $display("FAIL lat3_bubbles got=%0d expected=3", n_bub);
    end
    checks++;
    if (cst_w[1] !== 16'(cnt_exp(m_st[1]))) begin
      errors++; $display("FAIL lat3_stall_cnt got=%0d expected=%0d", cst_w[1], cnt_exp(m_st[1]));
    end
  endtask

  task automatic test_flush();
    idle();
    id_valid = 1; id_rb_addr = 5'd7; ex_wr_en = 1; ex_wr_addr = 5'd7; ex_is_load = 1;
    apply();
    ex_wr_en = 0; ex_is_load = 0; flush = 1;
    apply();
    checks++;
    if ({act_st[1], bv_w[1]} !== 2'b00) begin
      errors++; $display("FAIL flush_drop got=%b expected=00", {act_st[1], bv_w[1]});
    end
    flush = 0; ex_wr_en = 1; ex_result = $urandom;
    for (int k = 0; k < 2; k++) begin
      apply();
      for (int ln = 0; ln < 2; ln++) begin
        checks++;
        if (act_st[ln] !== exp_st[ln]) begin
          errors++; $display("FAIL flush_seq_stall lane%0d got=%0b expected=%0b", ln, act_st[ln], exp_st[ln]);
        end
        checks++;
        if ({bv_w[ln], src_w[ln], bb_w[ln]} !== exp_out[ln]) begin
          errors++; $display("FAIL flush_seq_out lane%0d got=%h expected=%h", ln, {bv_w[ln], src_w[ln], bb_w[ln]}, exp_out[ln]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    idle();
    id_valid = 1; id_rb_addr = 5'd9; ex_wr_en = 1; ex_wr_addr = 5'd9; ex_is_load = 1;
    apply();
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    cyc++;
    checks++;
    if ({st_w[1], bv_w[1], bb_w[1], src_w[1]} !== 36'd0) begin
      errors++; $display("FAIL reset_mid_stall got=%h expected=0", {st_w[1], bv_w[1], bb_w[1], src_w[1]});
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      id_valid   = ($urandom_range(0, 3) != 0);
      id_mb      = ($urandom_range(0, 4) == 0);
      id_rb_addr = 5'($urandom_range(0, 3));
      ex_wr_en   = ($urandom_range(0, 1) != 0);
      ex_wr_addr = 5'($urandom_range(0, 3));
      ex_is_load = ($urandom_range(0, 2) == 0);
      wb_wr_en   = ($urandom_range(0, 1) != 0);
      wb_wr_addr = 5'($urandom_range(0, 3));
      flush      = ($urandom_range(0, 19) == 0);
      id_b_data = $urandom; id_const = $urandom; ex_result = $urandom; bus_d = $urandom;
      apply();
      for (int ln = 0; ln < 2; ln++) begin
        checks++;
        if (act_st[ln] !== exp_st[ln]) begin
          errors++; $display("FAIL rand_stall lane%0d cyc%0d got=%0b expected=%0b", ln, k, act_st[ln], exp_st[ln]);
        end
        checks++;
        if ({bv_w[ln], src_w[ln], bb_w[ln]} !== exp_out[ln]) begin
          errors++; $display("FAIL rand_out lane%0d cyc%0d got=%h expected=%h", ln, k, {bv_w[ln], src_w[ln], bb_w[ln]}, exp_out[ln]);
        end
        checks++;
        if ({cex_w[ln], cwb_w[ln], cst_w[ln]} !==
            {16'(cnt_exp(m_ex[ln])), 16'(cnt_exp(m_wb[ln])), 16'(cnt_exp(m_st[ln]))}) begin
          errors++; $display("FAIL rand_cnt lane%0d cyc%0d got=%h expected=%0d/%0d/%0d", ln, k,
                             {cex_w[ln], cwb_w[ln], cst_w[ln]}, cnt_exp(m_ex[ln]), cnt_exp(m_wb[ln]), cnt_exp(m_st[ln]));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_const();
    test_ex_priority();
    test_r0();
    test_load_use_lat1();
    test_load_use_lat3();
    test_flush();
    test_reset_mid_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
